// File: rtl/gf180mcu_osu_sc_9t_lshifdn_rx.sv
// ---------------------------------------------------------------------------
// gf180mcu_osu_sc_9t_lshifdn_rx
//
// Core-side receiver for traffic crossing down from the high-voltage pad
// domain through down-direction level shifters. It implements a bundled-data,
// four-phase REQ/ACK handshake. REQ_IN is synchronised. D_IN is sampled
// unsynchronised, and only on the capture edge, because the far side holds it
// stable while REQ_IN=1. A sticky ERR flags a handshake that stays stuck in
// ACK_HIGH for too long.
//
// Parameters
//   W            data word width (1..32)
//   SYNC_STAGES  flops in the REQ_IN synchroniser chain (2..4)
//   TIMEOUT      cycles allowed in ACK_HIGH before ERR sets; 0 disables
//
// Ports
//   CLK      in   core clock, rising edge
//   RN       in   asynchronous active-low reset
//   ISO_EN   in   far domain isolated: REQ_IN / D_IN treated as invalid
//   REQ_IN   in   asynchronous request from the level shifter
//   D_IN     in   [W] bundled data
//   PAR_IN   in   odd-parity bit bundled with D_IN     (parity build only)
//   ERR_CLR  in   synchronous clear of ERR
//   ACK_OUT  out  registered acknowledge to the far domain
//   Q        out  [W] last captured word
//   VALID    out  one-cycle pulse when Q updates
//   ERR      out  sticky fault flag
//   BUSY     out  FSM is in ACK_HIGH
//   PERR     out  parity error of the last capture     (parity build only)
//
// Optional feature macro: GF180MCU_OSU_SC_LSHIFDN_PARITY_EN
//   When defined, the block adds PAR_IN and PERR. A capture with bad (even)
//   parity sets PERR and also sets ERR. Q is still updated.
// ---------------------------------------------------------------------------
module gf180mcu_osu_sc_9t_lshifdn_rx #(
  parameter int unsigned W           = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic         CLK,
  input  logic         RN,
  input  logic         ISO_EN,
  input  logic         REQ_IN,
  input  logic [W-1:0] D_IN,
`ifdef GF180MCU_OSU_SC_LSHIFDN_PARITY_EN
  input  logic         PAR_IN,
  output logic         PERR,
`endif
  input  logic         ERR_CLR,
  output logic         ACK_OUT,
  output logic [W-1:0] Q,
  output logic         VALID,
  output logic         ERR,
  output logic         BUSY
);

  // The counter only needs to reach TIMEOUT, where it saturates. When
  // TIMEOUT is 0, CNT_MAX is also 0, so the counter never moves.
  localparam int unsigned CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  typedef enum logic {
    IDLE     = 1'b0,
    ACK_HIGH = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;
  logic                   req_v;

  logic                   ack_q,   ack_d;
  logic [W-1:0]           q_q,     q_d;
  logic                   valid_q, valid_d;
  logic                   err_q,   err_d;
  logic                   busy_q,  busy_d;
  logic [CW-1:0]          cnt_q,   cnt_d;

  logic                   capture;
  logic                   cnt_inc;
  logic                   tmo_evt;

`ifdef GF180MCU_OSU_SC_LSHIFDN_PARITY_EN
  logic                   perr_q, perr_d;
  logic                   par_bad;
`endif

  // -------------------------------------------------------------------------
  // REQ_IN synchroniser. Isolation is applied after the chain. When ISO_EN
  // drops, the chain is therefore already settled, and a stale REQ can never
  // be seen as a fresh edge.
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], REQ_IN};
    end
  end

  assign req_s = sync_q[SYNC_STAGES-1];
  assign req_v = req_s & ~ISO_EN;

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (req_v)  state_d = ACK_HIGH;
      ACK_HIGH: if (!req_v) state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM outputs and datapath next values
  // -------------------------------------------------------------------------
  assign capture = (state_q == IDLE) && req_v;

  // The counter advances only while the handshake is being held. It stops at
  // CNT_MAX, so the timeout fires once per stuck handshake.
  assign cnt_inc = (state_q == ACK_HIGH) && req_v && (cnt_q != CNT_MAX);
  assign tmo_evt = cnt_inc && ((cnt_q + CW'(1)) == CNT_MAX);

`ifdef GF180MCU_OSU_SC_LSHIFDN_PARITY_EN
  // Odd parity is expected over {D_IN, PAR_IN}.
  assign par_bad = ~((^D_IN) ^ PAR_IN);
`endif

  always_comb begin
    ack_d   = ack_q;
    q_d     = q_q;
    valid_d = 1'b0;
    err_d   = err_q;
    busy_d  = (state_d == ACK_HIGH);
    cnt_d   = cnt_q;
`ifdef GF180MCU_OSU_SC_LSHIFDN_PARITY_EN
    perr_d  = perr_q;
`endif

    if (capture) begin
      ack_d   = 1'b1;
      q_d     = D_IN;
      valid_d = 1'b1;
      cnt_d   = '0;
`ifdef GF180MCU_OSU_SC_LSHIFDN_PARITY_EN
      perr_d  = par_bad;
`endif
    end else if ((state_q == ACK_HIGH) && !req_v) begin
      ack_d = 1'b0;
    end else if (cnt_inc) begin
      cnt_d = cnt_q + CW'(1);
    end

    // A clear and a new fault on the same edge: the fault wins.
    if (ERR_CLR) begin
      err_d = 1'b0;
    end
    if (tmo_evt) begin
      err_d = 1'b1;
    end
`ifdef GF180MCU_OSU_SC_LSHIFDN_PARITY_EN
    if (capture && par_bad) begin
      err_d = 1'b1;
    end
`endif
  end

  // -------------------------------------------------------------------------
  // Output and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      ack_q   <= 1'b0;
      q_q     <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      ack_q   <= ack_d;
      q_q     <= q_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef GF180MCU_OSU_SC_LSHIFDN_PARITY_EN
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
    end
  end

  assign PERR = perr_q;
`endif

  assign ACK_OUT = ack_q;
  assign Q       = q_q;
  assign VALID   = valid_q;
  assign ERR     = err_q;
  assign BUSY    = busy_q;

endmodule

// File: tb/tb_gf180mcu_osu_sc_9t_lshifdn_rx.sv
// ---------------------------------------------------------------------------
// Bench for gf180mcu_osu_sc_9t_lshifdn_rx. The bench has two instances:
//   dut    default timeout (255), used for the handshake, isolation, reset,
//          back-to-back, parity and random traffic
//   dut_t  TIMEOUT=4, used for the stuck-handshake checks
// Expected words are queued when a request is issued. A negedge monitor pops
// one word each time VALID is seen.
// ---------------------------------------------------------------------------
module tb_gf180mcu_osu_sc_9t_lshifdn_rx;

  localparam int unsigned W       = 8;
  localparam int unsigned S       = 2;
  localparam int unsigned T       = 4;
  localparam int          SPACING = 2 * (S + 1);

  logic         clk    = 1'b0;
  logic         rn     = 1'b0;
  logic         iso    = 1'b0;
  logic         req    = 1'b0;
  logic         errclr = 1'b0;
  logic [W-1:0] din    = '0;

  logic         ack,   vld,   err,   busy;
  logic [W-1:0] q;
  logic         ack_t, vld_t, err_t, busy_t;
  logic [W-1:0] q_t;

`ifdef GF180MCU_OSU_SC_LSHIFDN_PARITY_EN
  logic         par = 1'b0;
  logic         perr, perr_t;
`endif

  int           n_cmp      = 0;
  int           n_bad      = 0;
  int           n_push     = 0;
  int           n_valid    = 0;
  int           cyc_n      = 0;
  int           last_valid = -1;
  logic [W-1:0] sb[$];

  gf180mcu_osu_sc_9t_lshifdn_rx #(.W(W), .SYNC_STAGES(S), .TIMEOUT(255)) dut (
    .CLK(clk), .RN(rn), .ISO_EN(iso), .REQ_IN(req), .D_IN(din),
`ifdef GF180MCU_OSU_SC_LSHIFDN_PARITY_EN
    .PAR_IN(par), .PERR(perr),
`endif
    .ERR_CLR(errclr), .ACK_OUT(ack), .Q(q), .VALID(vld), .ERR(err), .BUSY(busy)
  );

  gf180mcu_osu_sc_9t_lshifdn_rx #(.W(W), .SYNC_STAGES(S), .TIMEOUT(T)) dut_t (
    .CLK(clk), .RN(rn), .ISO_EN(iso), .REQ_IN(req), .D_IN(din),
`ifdef GF180MCU_OSU_SC_LSHIFDN_PARITY_EN
    .PAR_IN(par), .PERR(perr_t),
`endif
    .ERR_CLR(errclr), .ACK_OUT(ack_t), .Q(q_t), .VALID(vld_t), .ERR(err_t), .BUSY(busy_t)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc_n++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic [W-1:0] w);
    sb.push_back(w);
    n_push++;
  endtask

  // Odd parity over {word, parity bit}.
  function automatic logic odd_par(input logic [W-1:0] w);
    logic ones;
    ones = 1'b0;
    for (int unsigned i = 0; i < W; i++) ones = ones ^ w[i];
    return ~ones;
  endfunction

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_ack(input logic lvl, input string nm);
    int k;
    k = 0;
    while (ack !== lvl && k < 40) begin
      cyc(1);
      k++;
    end
    chk(nm, ack, lvl);
  endtask

  // Compliant four-phase far side.
  task automatic hs(input logic [W-1:0] w, input int hold, input int gap);
    din = w;
`ifdef GF180MCU_OSU_SC_LSHIFDN_PARITY_EN
    par = odd_par(w);
`endif
    req = 1'b1;
    push(w);
    wait_ack(1'b1, "hs_ack_rise");
    cyc(hold);
    req = 1'b0;
    din = W'($urandom);
    wait_ack(1'b0, "hs_ack_fall");
    cyc(gap);
  endtask

  // Toggle REQ_IN and D_IN under isolation: no capture may result.
  task automatic iso_try();
    iso = 1'b1;
    cyc(1);
    repeat (4) begin
      req = ~req;
      din = '1;
      cyc(1 + int'($urandom_range(0, 2)));
    end
    req = 1'b0;
    cyc(S + 2);
    iso = 1'b0;
    cyc(1);
    chk("iso_try_no_ack", ack, 1'b0);
  endtask

  // Scoreboard monitor
  initial forever begin
    @(negedge clk);
    if (!rn) begin
      last_valid = -1;
    end else if (vld === 1'b1) begin
      n_valid++;
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_valid: actual VALID=1 Q=0x%0h required no VALID", q);
      end else begin
        chk("q_on_valid", q, sb.pop_front());
      end
      if (last_valid >= 0) chk("valid_spacing_ok", 32'((cyc_n - last_valid) >= SPACING), 1);
      last_valid = cyc_n;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: actual=timeout required=finish");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int v0;

    // Reset state
    cyc(2);
    chk("rst_ack",   ack,   1'b0);
    chk("rst_q",     q,     '0);
    chk("rst_valid", vld,   1'b0);
    chk("rst_err",   err,   1'b0);
    chk("rst_busy",  busy,  1'b0);
    chk("rst_err_t", err_t, 1'b0);
    rn = 1'b1;
    cyc(2);

    // Reset mid-handshake, then recapture with REQ still held
    din = 8'hA5;
    req = 1'b1;
    push(8'hA5);
    wait_ack(1'b1, "midrst_ack_rise");
    cyc(1);
    #2 rn = 1'b0;
    #1;
    chk("midrst_ack",   ack,  1'b0);
    chk("midrst_q",     q,    '0);
    chk("midrst_valid", vld,  1'b0);
    chk("midrst_err",   err,  1'b0);
    chk("midrst_busy",  busy, 1'b0);
    push(8'hA5);
    cyc(2);
    rn = 1'b1;
    wait_ack(1'b1, "midrst_recapture");
    cyc(1);
    chk("midrst_q_after", q, 8'hA5);
    req = 1'b0;
    wait_ack(1'b0, "midrst_ack_fall");
    cyc(2);

    // Basic handshake latency
    din = 8'h3C;
`ifdef GF180MCU_OSU_SC_LSHIFDN_PARITY_EN
    par = odd_par(8'h3C);
`endif
    req = 1'b1;
    push(8'h3C);
    cyc(2);
    chk("basic_ack_early",   ack, 1'b0);
    chk("basic_valid_early", vld, 1'b0);
    cyc(1);
    chk("basic_ack_rise",  ack,  1'b1);
    chk("basic_valid",     vld,  1'b1);
    chk("basic_q",         q,    8'h3C);
    chk("basic_busy",      busy, 1'b1);
    cyc(1);
    chk("basic_valid_one", vld,  1'b0);
    chk("basic_ack_hold",  ack,  1'b1);
    req = 1'b0;
    cyc(2);
    chk("basic_ack_fall_early", ack, 1'b1);
    cyc(1);
    chk("basic_ack_fall", ack,  1'b0);
    chk("basic_busy_low", busy, 1'b0);
    cyc(4);
    chk("basic_valid_count", n_valid, n_push);

    // Isolation while in ACK_HIGH
    din = 8'h5C;
`ifdef GF180MCU_OSU_SC_LSHIFDN_PARITY_EN
    par = odd_par(8'h5C);
`endif
    req = 1'b1;
    push(8'h5C);
    wait_ack(1'b1, "iso_ack_rise");
    iso = 1'b1;
    cyc(1);
    chk("iso_ack_drop",  ack,  1'b0);
    chk("iso_busy_drop", busy, 1'b0);
    chk("iso_err",       err,  1'b0);
    chk("iso_q_kept",    q,    8'h5C);
    repeat (6) begin
      req = ~req;
      din = '1;
      cyc(2);
    end
    chk("iso_q_after_toggle", q, 8'h5C);
    req = 1'b0;
    cyc(S + 2);
    iso = 1'b0;
    cyc(2);
    chk("iso_release_ack", ack, 1'b0);

    // Back-to-back words
    v0 = n_valid;
    hs(8'h01, 0, 0);
    hs(8'h02, 0, 0);
    hs(8'h03, 0, 3);
    chk("b2b_three_valids", n_valid - v0, 3);

    // Timeout on the TIMEOUT=4 instance
    errclr = 1'b1;
    cyc(1);
    errclr = 1'b0;
    chk("tmo_err_cleared", err_t, 1'b0);
    din = 8'h5A;
`ifdef GF180MCU_OSU_SC_LSHIFDN_PARITY_EN
    par = odd_par(8'h5A);
`endif
    req = 1'b1;
    push(8'h5A);
    cyc(3);
    chk("tmo_ack_rise", ack_t, 1'b1);
    chk("tmo_err_0",    err_t, 1'b0);
    cyc(3);
    chk("tmo_err_before", err_t, 1'b0);
    errclr = 1'b1;
    cyc(1);
    errclr = 1'b0;
    chk("tmo_err_set_wins", err_t, 1'b1);
    chk("tmo_ack_held",     ack_t, 1'b1);
    cyc(3);
    chk("tmo_err_sticky", err_t,  1'b1);
    chk("tmo_busy",       busy_t, 1'b1);
    errclr = 1'b1;
    cyc(1);
    errclr = 1'b0;
    chk("tmo_err_clr", err_t, 1'b0);
    cyc(4);
    chk("tmo_no_reset", err_t, 1'b0);
    chk("tmo_ack_still", ack_t, 1'b1);
    req = 1'b0;
    cyc(3);
    chk("tmo_ack_fall",  ack_t, 1'b0);
    chk("tmo_main_fall", ack,   1'b0);
    chk("tmo_main_err",  err,   1'b0);
    cyc(2);

`ifdef GF180MCU_OSU_SC_LSHIFDN_PARITY_EN
    // Parity
    din = 8'h07;
    par = 1'b0;
    req = 1'b1;
    push(8'h07);
    wait_ack(1'b1, "par_ok_ack");
    chk("par_ok_perr", perr, 1'b0);
    chk("par_ok_err",  err,  1'b0);
    req = 1'b0;
    wait_ack(1'b0, "par_ok_fall");
    cyc(1);
    din = 8'h07;
    par = 1'b1;
    req = 1'b1;
    push(8'h07);
    wait_ack(1'b1, "par_bad_ack");
    chk("par_bad_perr", perr, 1'b1);
    chk("par_bad_err",  err,  1'b1);
    chk("par_bad_q",    q,    8'h07);
    req = 1'b0;
    wait_ack(1'b0, "par_bad_fall");
    errclr = 1'b1;
    cyc(1);
    errclr = 1'b0;
    chk("par_err_clr",   err,  1'b0);
    chk("par_perr_held", perr, 1'b1);
    cyc(2);
`endif

    // Random traffic
    repeat (40) begin
      if ($urandom_range(0, 5) == 0) iso_try();
      else hs(W'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end
    cyc(10);
    chk("sb_empty",       sb.size(), 0);
    chk("valid_count",    n_valid,   n_push);
    chk("main_err_final", err,       1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gf180mcu_osu_sc_9t_lshifdn_rx.md
Name: gf180mcu_osu_sc_9T_lshifdn_rx

Overview:
- Receive-side controller for signals arriving from the high-voltage pad domain through down-direction level shifters into the core clock domain.
- Synchronises a bundled-data four-phase REQ/ACK handshake and captures a W-bit word.
- Honours an isolation clamp while the far domain is unpowered.
- Flags a stuck handshake with a timeout.
- Counterpart of the library's up-shift path: this block is the core-side receiver for traffic going down.

Parameters:
- W, 8, data word width (1..32).
- SYNC_STAGES, 2, flops in the REQ_IN synchroniser chain (2..4).
- TIMEOUT, 255, cycles allowed in ACK_HIGH before ERR sets; 0 disables the timeout.

Ports:
- CLK  input  1  core clock, rising edge.
- RN  input  1  asynchronous active-low reset.
- ISO_EN  input  1  1 = far domain isolated; REQ_IN and D_IN are treated as invalid.
- REQ_IN  input  1  asynchronous request from the level shifter.
- D_IN  input  W  bundled data; stable whenever REQ_IN=1.
- ERR_CLR  input  1  synchronous clear of ERR.
- ACK_OUT  output  1  acknowledge returned to the far domain (registered).
- Q  output  W  last captured word (registered).
- VALID  output  1  one-cycle pulse when Q updates.
- ERR  output  1  sticky fault flag.
- BUSY  output  1  1 while the FSM is in ACK_HIGH.

Behaviour:
- Reset (RN=0, async): sync chain, ACK_OUT, Q, VALID, ERR, BUSY and the timeout counter all go to 0; state = IDLE. Release is taken on a clock edge; no output glitches on release.
- Synchroniser:
  - req_s = last stage of the SYNC_STAGES chain sampling REQ_IN.
  - req_q = req_s & ~ISO_EN; ISO_EN is applied after the chain.
  - D_IN is never synchronised; it is sampled only on the capture edge.
- FSM states: IDLE, ACK_HIGH.
  - IDLE, req_q=1: Q<=D_IN, VALID<=1 for one cycle, ACK_OUT<=1, counter<=0, go to ACK_HIGH.
  - ACK_HIGH, req_q=0: ACK_OUT<=0, go to IDLE.
  - ACK_HIGH, req_q=1: counter increments, saturating.
- Latency: ACK_OUT and VALID rise after the (SYNC_STAGES+1)th rising edge at which REQ_IN=1 is sampled. ACK_OUT falls SYNC_STAGES+1 edges after REQ_IN=0 is first sampled.
- Back-to-back: a new capture requires a return through IDLE. No two VALID pulses are closer than 2*(SYNC_STAGES+1) cycles.
- Timeout (TIMEOUT>0): when the counter reaches TIMEOUT in ACK_HIGH, ERR<=1. The FSM stays in ACK_HIGH with ACK_OUT held at 1; it does not abort.
- ISO_EN asserted in ACK_HIGH: req_q=0, so the next edge drops ACK_OUT and returns to IDLE. ERR is not set. Q is retained.
- ISO_EN asserted in IDLE: no capture occurs regardless of REQ_IN.
- ERR_CLR=1: ERR<=0 on that edge. A timeout event on the same edge wins, so ERR=1.
- BUSY = (state==ACK_HIGH), registered with the state.
- Q holds its value between captures. VALID is never high for two consecutive cycles.

Optional Feature:
- Macro: GF180MCU_OSU_SC_LSHIFDN_PARITY_EN.
- Defined:
  - Adds input PAR_IN (1 bit, bundled with D_IN) and output PERR (1 bit, reset 0).
  - On the capture edge, PERR<=(^D_IN)^PAR_IN^1, i.e. odd parity is expected; PERR is held until the next capture.
  - A parity error also sets ERR.
  - Q is still updated.
- Not defined: neither port exists and ERR is driven only by the timeout.

Test Plan:
- Reset mid-handshake: W=8, SYNC_STAGES=2. Drive REQ_IN=1, D_IN=0xA5; assert RN=0 after ACK_OUT=1. Required: ACK_OUT, Q, VALID, ERR, BUSY are 0 immediately, without waiting for a clock edge. After release with REQ_IN still 1, capture recurs with Q=0xA5.
- Basic handshake: REQ_IN rises with D_IN=0x3C. Required: ACK_OUT=1 and VALID=1 for one cycle after the 3rd sampling edge, Q=0x3C. Drop REQ_IN: ACK_OUT=0 after 3 edges. No second VALID.
- Timeout: TIMEOUT=4, REQ_IN held at 1. Required: ERR=1 on the 4th cycle after ACK_OUT rises, ACK_OUT stays 1. Pulse ERR_CLR with REQ_IN still 1: ERR returns to 0 and does not re-set, since the counter is saturated and the condition is not a new event. Then drop REQ_IN: ACK_OUT falls.
- Isolation: in ACK_HIGH, set ISO_EN=1 with REQ_IN=1. Required: ACK_OUT=0 and BUSY=0 one edge later, ERR=0, Q unchanged. Toggling REQ_IN and D_IN=0xFF while ISO_EN=1 produces no VALID.
- Back-to-back words: words 0x01, 0x02, 0x03 under a compliant four-phase far side. Required: exactly 3 VALID pulses, Q sequence 0x01, 0x02, 0x03, VALID spacing of at least 6 cycles.
- Parity (macro defined): D_IN=0x07, PAR_IN=0 gives PERR=0, ERR=0. D_IN=0x07, PAR_IN=1 gives PERR=1, ERR=1, Q=0x07.
